// File: rtl/rem_mod_n_serial_if.sv
// Digit stream and remainder status bundle for rem_mod_n_serial.
// master drives the digit stream; slave is the remainder engine.
interface rem_mod_n_serial_if #(
  parameter int unsigned MOD   = 3,
  parameter int unsigned K     = 1,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned RW = (MOD > 2) ? $clog2(MOD) : 1;

  logic             start;
  logic             mode;
  logic             in_valid;
  logic [K-1:0]     in_digit;
  logic [RW-1:0]    rem;
  logic             rem_valid;
  logic             divisible;
  logic [CNT_W-1:0] digit_cnt;

  modport master (
    output start, mode, in_valid, in_digit,
    input  rem, rem_valid, divisible, digit_cnt
  );

  modport slave (
    input  start, mode, in_valid, in_digit,
    output rem, rem_valid, divisible, digit_cnt
  );
endinterface

// File: rtl/rem_mod_n_serial.sv
// Serial remainder engine: running value mod MOD over K-bit digits, MSB- or LSB-first.
// Define REM_MOD_N_REG_OUT_EN to add one output register stage (2-edge latency).
module rem_mod_n_serial #(
  parameter int unsigned MOD   = 3,
  parameter int unsigned K     = 1,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  rem_mod_n_serial_if.slave bus
);
  localparam int unsigned RW = (MOD > 2) ? $clog2(MOD) : 1;
  // Wide enough for rem*2^K + digit and rem + digit*weight without overflow.
  localparam int unsigned PW = RW + K + 1;
  localparam logic [RW-1:0] W_ONE = RW'(1 % MOD);

  typedef enum logic {StIdle, StAcc} state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [RW-1:0]    weight_q, weight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;

  logic [RW-1:0]    rem_base, weight_base;
  logic [CNT_W-1:0] cnt_base;
  logic             cur_mode;
  logic [PW-1:0]    msb_sum, lsb_sum, w_shift;

  always_comb begin
    // A digit arriving together with start is the first digit of the new number.
    rem_base    = bus.start ? '0 : rem_q;
    weight_base = bus.start ? W_ONE : weight_q;
    cnt_base    = bus.start ? '0 : cnt_q;
    cur_mode    = bus.start ? bus.mode : mode_q;

    msb_sum = (PW'(rem_base) << K) + PW'(bus.in_digit);
    lsb_sum = PW'(rem_base) + PW'(bus.in_digit) * PW'(weight_base);
    w_shift = PW'(weight_base) << K;

    state_d  = state_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    weight_d = weight_q;
    cnt_d    = cnt_q;
    div_d    = div_q;

    if (bus.start) begin
      state_d  = StIdle;
      mode_d   = bus.mode;
      rem_d    = '0;
      weight_d = W_ONE;
      cnt_d    = '0;
      div_d    = 1'b0;
    end

    if (bus.in_valid) begin
      state_d  = StAcc;
      rem_d    = RW'((cur_mode ? lsb_sum : msb_sum) % PW'(MOD));
      weight_d = RW'(w_shift % PW'(MOD));
      cnt_d    = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
      div_d    = (rem_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      mode_q   <= 1'b0;
      rem_q    <= '0;
      weight_q <= W_ONE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      weight_q <= weight_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
    end
  end

`ifdef REM_MOD_N_REG_OUT_EN
  logic [RW-1:0]    rem_out_q;
  logic             valid_out_q;
  logic             div_out_q;
  logic [CNT_W-1:0] cnt_out_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_out_q   <= '0;
      valid_out_q <= 1'b0;
      div_out_q   <= 1'b0;
      cnt_out_q   <= '0;
    end else begin
      rem_out_q   <= rem_q;
      valid_out_q <= (state_q == StAcc);
      div_out_q   <= div_q;
      cnt_out_q   <= cnt_q;
    end
  end

  assign bus.rem       = rem_out_q;
  assign bus.rem_valid = valid_out_q;
  assign bus.divisible = div_out_q;
  assign bus.digit_cnt = cnt_out_q;
`else
  assign bus.rem       = rem_q;
  assign bus.rem_valid = (state_q == StAcc);
  assign bus.divisible = div_q;
  assign bus.digit_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_rem_mod_n_serial.sv
// Directed bench for rem_mod_n_serial over several MOD/K/CNT_W configurations.
// Output latency follows REM_MOD_N_REG_OUT_EN.
module tb_rem_mod_n_serial;
`ifdef REM_MOD_N_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rem_mod_n_serial_if #(.MOD(3), .K(1), .CNT_W(8)) b3 ();
  rem_mod_n_serial_if #(.MOD(5), .K(2), .CNT_W(8)) b5 ();
  rem_mod_n_serial_if #(.MOD(7), .K(2), .CNT_W(8)) b7 ();
  rem_mod_n_serial_if #(.MOD(3), .K(1), .CNT_W(2)) bc ();

  rem_mod_n_serial #(.MOD(3), .K(1), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .bus(b3));
  rem_mod_n_serial #(.MOD(5), .K(2), .CNT_W(8)) u5 (.clk(clk), .rst(rst), .bus(b5));
  rem_mod_n_serial #(.MOD(7), .K(2), .CNT_W(8)) u7 (.clk(clk), .rst(rst), .bus(b7));
  rem_mod_n_serial #(.MOD(3), .K(1), .CNT_W(2)) uc (.clk(clk), .rst(rst), .bus(bc));

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    total++;
    assert (obs === 32'(exp_v)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic idle_all();
    b3.start = 1'b0; b3.mode = 1'b0; b3.in_valid = 1'b0; b3.in_digit = '0;
    b5.start = 1'b0; b5.mode = 1'b0; b5.in_valid = 1'b0; b5.in_digit = '0;
    b7.start = 1'b0; b7.mode = 1'b0; b7.in_valid = 1'b0; b7.in_digit = '0;
    bc.start = 1'b0; bc.mode = 1'b0; bc.in_valid = 1'b0; bc.in_digit = '0;
  endtask

  // One beat on the selected DUT, then wait out the output latency; ends at a negedge.
  task automatic beat(input int sel, input int st, input int md, input int vl, input int dg);
    @(negedge clk);
    case (sel)
      0: begin b3.start = 1'(st); b3.mode = 1'(md); b3.in_valid = 1'(vl); b3.in_digit = 1'(dg); end
      1: begin b5.start = 1'(st); b5.mode = 1'(md); b5.in_valid = 1'(vl); b5.in_digit = 2'(dg); end
      2: begin b7.start = 1'(st); b7.mode = 1'(md); b7.in_valid = 1'(vl); b7.in_digit = 2'(dg); end
      default: begin
        bc.start = 1'(st); bc.mode = 1'(md); bc.in_valid = 1'(vl); bc.in_digit = 1'(dg);
      end
    endcase
    @(posedge clk);
    @(negedge clk);
    idle_all();
    if (LAT == 2) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_out(input int sel, input string tag, input int r, input int c,
                           input int v, input int d);
    case (sel)
      0: begin
        chk({tag, ".rem"}, 32'(b3.rem), r);       chk({tag, ".cnt"}, 32'(b3.digit_cnt), c);
        chk({tag, ".vld"}, 32'(b3.rem_valid), v); chk({tag, ".div"}, 32'(b3.divisible), d);
      end
      1: begin
        chk({tag, ".rem"}, 32'(b5.rem), r);       chk({tag, ".cnt"}, 32'(b5.digit_cnt), c);
        chk({tag, ".vld"}, 32'(b5.rem_valid), v); chk({tag, ".div"}, 32'(b5.divisible), d);
      end
      2: begin
        chk({tag, ".rem"}, 32'(b7.rem), r);       chk({tag, ".cnt"}, 32'(b7.digit_cnt), c);
        chk({tag, ".vld"}, 32'(b7.rem_valid), v); chk({tag, ".div"}, 32'(b7.divisible), d);
      end
      default: begin
        chk({tag, ".rem"}, 32'(bc.rem), r);       chk({tag, ".cnt"}, 32'(bc.digit_cnt), c);
        chk({tag, ".vld"}, 32'(bc.rem_valid), v); chk({tag, ".div"}, 32'(bc.divisible), d);
      end
    endcase
  endtask

  initial begin
    int val;
    int b;
    idle_all();

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out(0, "rst0", 0, 0, 0, 0);
    check_out(3, "rstc", 0, 0, 0, 0);
    rst = 1'b1;

    // MOD3 K1 MSB-first 1,0,1,1
    beat(0, 1, 0, 0, 0);
    check_out(0, "msb3.start", 0, 0, 0, 0);
    beat(0, 0, 0, 1, 1); check_out(0, "msb3.d1", 1, 1, 1, 0);
    beat(0, 0, 0, 1, 0); check_out(0, "msb3.d2", 2, 2, 1, 0);
    beat(0, 0, 0, 1, 1); check_out(0, "msb3.d3", 2, 3, 1, 0);
    beat(0, 0, 0, 1, 1); check_out(0, "msb3.d4", 2, 4, 1, 0);

    // MOD3 K1 LSB-first 1,1,0,1
    beat(0, 1, 1, 0, 0);
    check_out(0, "lsb3.start", 0, 0, 0, 0);
    beat(0, 0, 0, 1, 1); check_out(0, "lsb3.d1", 1, 1, 1, 0);
    beat(0, 0, 0, 1, 1); check_out(0, "lsb3.d2", 0, 2, 1, 1);
    beat(0, 0, 0, 1, 0); check_out(0, "lsb3.d3", 0, 3, 1, 1);
    beat(0, 0, 0, 1, 1); check_out(0, "lsb3.d4", 2, 4, 1, 0);

    // MOD5 K2 MSB-first 3,2,1; MOD7 K2 LSB-first 3,2,1
    beat(1, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 3); check_out(1, "msb5.d1", 3, 1, 1, 0);
    beat(1, 0, 0, 1, 2); check_out(1, "msb5.d2", 4, 2, 1, 0);
    beat(1, 0, 0, 1, 1); check_out(1, "msb5.d3", 2, 3, 1, 0);
    beat(2, 1, 1, 0, 0);
    beat(2, 0, 0, 1, 3); check_out(2, "lsb7.d1", 3, 1, 1, 0);
    beat(2, 0, 0, 1, 2); check_out(2, "lsb7.d2", 4, 2, 1, 0);
    beat(2, 0, 0, 1, 1); check_out(2, "lsb7.d3", 6, 3, 1, 0);

    // Mid-stream reset, start+in_valid, mode change without start
    beat(0, 1, 0, 0, 0);
    beat(0, 0, 0, 1, 1);
    beat(0, 0, 0, 1, 1); check_out(0, "mid.pre", 0, 2, 1, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out(0, "mid.rst", 0, 0, 0, 0);
    rst = 1'b1;
    beat(0, 1, 1, 1, 1); check_out(0, "mid.sv", 1, 1, 1, 0);
    beat(0, 0, 0, 1, 1); check_out(0, "mid.m1", 0, 2, 1, 1);
    beat(0, 0, 0, 1, 1); check_out(0, "mid.m2", 1, 3, 1, 0);
    beat(0, 0, 0, 1, 0); check_out(0, "mid.m3", 1, 4, 1, 0);

    // Counter saturation with CNT_W=2
    beat(3, 1, 0, 0, 0);
    beat(3, 0, 0, 1, 1); check_out(3, "sat.d1", 1, 1, 1, 0);
    beat(3, 0, 0, 1, 1); check_out(3, "sat.d2", 0, 2, 1, 1);
    beat(3, 0, 0, 1, 1); check_out(3, "sat.d3", 1, 3, 1, 0);
    beat(3, 0, 0, 1, 1); check_out(3, "sat.d4", 0, 3, 1, 1);
    beat(3, 0, 0, 1, 1); check_out(3, "sat.d5", 1, 3, 1, 0);
    repeat (3) @(negedge clk);
    check_out(3, "sat.hold", 1, 3, 1, 0);

    // Random bit streams against the integer value of the number
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 4; r++) begin
        beat(0, 1, m, 0, 0);
        val = 0;
        for (int i = 0; i < 8; i++) begin
          b = int'($urandom_range(0, 1));
          beat(0, 0, 0, 1, b);
          if (m == 0) val = val * 2 + b;
          else        val = val + (b << i);
          check_out(0, "rnd", val % 3, i + 1, 1, ((val % 3) == 0) ? 1 : 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rem_mod_n_serial.md
Name: rem_mod_n_serial

Overview:
- Serial remainder engine: consumes a number one K-bit digit per accepted beat and keeps a running remainder modulo a parameter MOD.
- Generalises the fixed mod-3, 1-bit, fixed-direction remainder FSMs to any MOD ≥ 2, any digit width, and a run-time direction mode: MSB-first ("added from right") or LSB-first ("added from left").
- Used by serial divisibility checkers and checksum front-ends in the examples tree.

Parameters:
- MOD, 3, modulus; legal range is 2 to 255.
- K, 1, bits per digit; legal range is 1 to 8.
- CNT_W, 8, width of the saturating digit counter.
- Derived localparam RW = (MOD > 2) ? $clog2(MOD) : 1. This is the remainder width.

Ports:
- clk  input  1  clock; all logic updates on posedge.
- rst  input  1  synchronous reset, active-low; it is sampled on posedge clk.
- start  input  1  begin a new number: clears accumulated state and latches mode.
- mode  input  1  0 = MSB-first (new digit is least significant); 1 = LSB-first (new digit is most significant). Sampled only when start=1.
- in_valid  input  1  in_digit is accepted on this edge.
- in_digit  input  K  digit value, 0..2^K-1.
- rem  output  RW  running remainder, value mod MOD, always in 0..MOD-1.
- rem_valid  output  1  at least one digit has been accepted since the last start or reset.
- divisible  output  1  rem_valid && rem == 0.
- digit_cnt  output  CNT_W  number of digits accepted, saturating at 2^CNT_W-1.

Behaviour:
- Reset (rst=0 at posedge):
  - rem=0, rem_valid=0, divisible=0, digit_cnt=0.
  - Internal weight register = 1 mod MOD. Internal mode_q = 0.
  - Reset overrides start and in_valid in the same cycle.
  - Reset mid-stream discards all accumulated state.
- State machine, two states:
  - IDLE: no digit accepted yet. Entered on reset or on start.
  - ACC: accumulating. Entered on the first accepted digit.
  - While in IDLE, rem_valid=0.
- MSB-first update (mode_q=0):
  - rem_next = (rem·2^K + in_digit) mod MOD.
  - Compute in RW+K+1 bits; no intermediate overflow is allowed.
- LSB-first update (mode_q=1):
  - rem_next = (rem + in_digit·weight) mod MOD.
  - weight_next = (weight·2^K) mod MOD.
  - weight holds 2^(K·n) mod MOD, where n = digits accepted so far.
- Latency:
  - A digit accepted at edge e is reflected in rem, divisible and digit_cnt immediately after edge e (one-cycle, registered).
  - The outputs are driven directly from state flops.
- start without in_valid:
  - Clears rem=0, weight=1 mod MOD, digit_cnt=0, rem_valid=0.
  - Latches mode into mode_q.
  - Next state is IDLE.
- start with in_valid in the same cycle:
  - The digit is treated as the first digit of the new number under the newly latched mode.
  - rem = in_digit mod MOD; weight = 2^K mod MOD; digit_cnt = 1; rem_valid = 1.
- in_valid=0 and start=0: all state holds.
- mode changes without start: ignored.
- digit_cnt: increments per accepted digit and saturates at all-ones without wrapping. Remainder accumulation continues past saturation.
- MOD=2: rem is 1 bit. MSB-first gives rem = LSB of the last digit. LSB-first weight becomes 0 after the first digit, so rem stays fixed.
- Digits with value ≥ MOD are legal and are reduced by the mod.

Optional Feature:
- Macro REM_MOD_N_REG_OUT_EN.
- Defined:
  - rem, divisible and digit_cnt pass through one extra output register stage; latency becomes 2 edges.
  - rem_valid is delayed identically so that it stays aligned.
  - Reset clears the output stage as well.
  - start clears the output stage one edge later, consistent with the 2-edge latency.
- Not defined: 1-edge latency as specified above.
- The benches check the latency that matches the macro.

Test Plan:
- MOD=3, K=1, start with mode=0, bits 1,0,1,1 (values 1,2,5,11) -> rem 1,2,2,2; divisible 0,0,0,0; digit_cnt 1,2,3,4.
- MOD=3, K=1, mode=1, bits 1,1,0,1 (values 1,3,3,11) -> rem 1,0,0,2; divisible 0,1,1,0.
- MOD=5, K=2, mode=0, digits 3,2,1 (values 3,14,57) -> rem 3,4,2. Then MOD=7, K=2, mode=1, digits 3,2,1 (values 3,11,27) -> rem 3,4,6.
- Mid-stream controls, MOD=3, K=1, mode=0:
  - Accept 1,1 (rem=0), then drive rst=0 for 2 cycles -> all outputs 0, rem_valid=0.
  - Then start+in_valid with mode=1, bit 1 -> rem=1, digit_cnt=1, rem_valid=1 after that edge.
  - Toggle mode without start, then send bit 1 -> rem=0, LSB-first retained (value 3).
- CNT_W=2, MOD=3, mode=0:
  - Send 5 ones -> digit_cnt 1,2,3,3,3 and rem 1,0,1,0,1.
  - In an idle gap with in_valid=0 for 3 cycles -> all outputs hold.
- Randomised: 4 runs of 8 random bits for each mode against a reference model (value mod MOD), repeated with REM_MOD_N_REG_OUT_EN defined and checked at 2-edge latency -> zero mismatches.
